// File: rtl/mont_pkg.sv
// ----------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the Montgomery-domain lift block:
//   MONT_R        Montgomery word size in bits (26)
//   mont_state_e  FSM state encoding {IDLE, PRE, RUN, DONE}
//   mont_shift()  total left shift S = R * ROUNDS applied by the lift
// ----------------------------------------------------------------------------
package mont_pkg;

    localparam int MONT_R = 26;

    // PRE only exists when the input pre-reduction step is compiled in; the
    // encoding is kept fixed so both builds share one state type.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mont_state_e;

    function automatic int mont_shift(input int r, input int rounds);
        return r * rounds;
    endfunction

endpackage

// File: rtl/mont_dbl_sub.sv
// ----------------------------------------------------------------------------
// mont_dbl_sub
// Combinational modular step: res = t mod q, where t = 2*acc (shift_en_i=1)
// or t = acc (shift_en_i=0). Valid whenever t < 2*q, so a single conditional
// subtraction is enough. The subtract is carried on Q_LEN+2 bits so that its
// MSB is a clean borrow (t - q < 0) even when t itself needs Q_LEN+1 bits.
//
// Ports:
//   acc_i       [Q_LEN-1:0]  current accumulator value
//   q_i         [Q_LEN-1:0]  odd modulus
//   shift_en_i               1: double before reducing, 0: reduce only
//   res_o       [Q_LEN-1:0]  reduced result, in [0, q)
// ----------------------------------------------------------------------------
module mont_dbl_sub
    import mont_pkg::*;
#(
    parameter int Q_LEN = 64
) (
    input  logic [Q_LEN-1:0] acc_i,
    input  logic [Q_LEN-1:0] q_i,
    input  logic             shift_en_i,
    output logic [Q_LEN-1:0] res_o
);

    logic [Q_LEN:0]   t;
    logic [Q_LEN+1:0] d;
    logic             unused_d_bit;

    assign t = shift_en_i ? {acc_i, 1'b0} : {1'b0, acc_i};
    assign d = {1'b0, t} - {2'b00, q_i};

    // Borrow set: t < q, keep t (which then fits in Q_LEN bits).
    // Borrow clear: 0 <= t - q < q, so the low Q_LEN bits hold the result.
    assign res_o = d[Q_LEN+1] ? t[Q_LEN-1:0] : d[Q_LEN-1:0];

    // d[Q_LEN] is always zero whenever it would be selected (t - q < q).
    assign unused_d_bit = d[Q_LEN];

endmodule

// File: rtl/mont_lift_r26.sv
// ----------------------------------------------------------------------------
// mont_lift_r26
// Montgomery-domain entry block: y = x * 2^S mod q with S = R * ROUNDS.
// One doubling-and-conditional-subtract step per clock, valid/ready on both
// the operand and the result side.
//
// Optional feature (compile-time macro MONT_LIFT_IN_RED_EN):
//   defined     - an extra PRE cycle reduces x once (x in [0, 2q) accepted),
//                 latency S+1, throughput one result per S+3 cycles.
//   not defined - no PRE state, callers guarantee x < q, latency S,
//                 throughput one result per S+2 cycles.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   q          modulus (odd), sampled on the input handshake
//   x          operand, sampled on the input handshake
//   in_valid   operand valid
//   in_ready   block is idle and will take an operand
//   y          result x * 2^S mod q, meaningful while out_valid is high
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts y
//   busy       block is not idle
// ----------------------------------------------------------------------------
module mont_lift_r26
    import mont_pkg::*;
#(
    parameter int Q_LEN  = 64,
    parameter int R      = MONT_R,
    parameter int ROUNDS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Q_LEN-1:0] q,
    input  logic [Q_LEN-1:0] x,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [Q_LEN-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int S     = mont_shift(R, ROUNDS);
    localparam int CNT_W = $clog2(S) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S - 1);

`ifdef MONT_LIFT_IN_RED_EN
    localparam mont_state_e LOAD_NEXT = PRE;
`else
    localparam mont_state_e LOAD_NEXT = RUN;
`endif

    mont_state_e      state_q, state_d;
    logic [Q_LEN-1:0] acc_q,   acc_d;
    logic [Q_LEN-1:0] qr_q,    qr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [Q_LEN-1:0] step_res;
    logic             step_shift;

    // The PRE step reuses the datapath as a plain "x mod q" reduce.
    assign step_shift = (state_q != PRE);

    mont_dbl_sub #(
        .Q_LEN (Q_LEN)
    ) u_dbl_sub (
        .acc_i      (acc_q),
        .q_i        (qr_q),
        .shift_en_i (step_shift),
        .res_o      (step_res)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = x;
                    qr_d    = q;
                    cnt_d   = '0;
                    state_d = LOAD_NEXT;
                end
            end

`ifdef MONT_LIFT_IN_RED_EN
            PRE: begin
                // Bring x from [0, 2q) into [0, q) so RUN's invariant holds.
                acc_d   = step_res;
                state_d = RUN;
            end
`endif

            RUN: begin
                acc_d = step_res;
                cnt_d = cnt_q + 1'b1;
                // cnt counts completed steps; the step taken while cnt
                // equals S-1 is the S-th and last one.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // in_valid is deliberately ignored here: a new operand is
                // only taken once the result has left and we are IDLE.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registers, so no input-to-output path.
    // acc_q is frozen in DONE, which keeps y stable under back-pressure.
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = acc_q;

endmodule

// File: tb/tb_mont_lift_r26.sv
// ----------------------------------------------------------------------------
// tb_mont_lift_r26
// Self-checking bench for mont_lift_r26. The reference is plain modular
// arithmetic (x * 2^26 mod q on 128 bits); a queue holds the expected result
// and accept edge of each operand, and a single monitor compares y, the
// result latency and the ready/busy decode on every negative clock edge.
// Optional build macro: MONT_LIFT_IN_RED_EN (adds one cycle of latency and
// the x >= q directed case).
// ----------------------------------------------------------------------------
module tb_mont_lift_r26;

    localparam int          S  = 26;
    localparam logic [63:0] QM = 64'h1FFF_FFFF_FFFF_FFFF;
`ifdef MONT_LIFT_IN_RED_EN
    localparam int LAT = S + 1;
`else
    localparam int LAT = S;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [63:0] q_in      = '0;
    logic [63:0] x_in      = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] y;

    typedef struct {
        logic [63:0] y;
        int          acc_edge;
    } exp_t;

    exp_t        exp_q[$];
    int          tests    = 0;
    int          fails    = 0;
    int          cyc      = 0;
    int          n_done   = 0;
    logic [63:0] last_y   = '0;
    bit          rand_rdy = 1'b0;
    bit          prev_ov  = 1'b0;

    mont_lift_r26 #(
        .Q_LEN  (64),
        .R      (26),
        .ROUNDS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .q         (q_in),
        .x         (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [63:0] xv, input logic [63:0] qv);
        logic [127:0] p;
        p = ({64'd0, xv} << S) % {64'd0, qv};
        return p[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand; returns the edge count at which it was accepted.
    task automatic send(input logic [63:0] qv, input logic [63:0] xv, output int acc_edge);
        int waited;
        waited   = 0;
        acc_edge = -1;
        q_in     = qv;
        x_in     = xv;
        in_valid = 1'b1;
        while (acc_edge < 0 && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                acc_edge = cyc + 1;
                exp_q.push_back('{model(xv, qv), acc_edge});
            end
            waited++;
        end
        if (acc_edge < 0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready never rose for x=0x%h", xv);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                check("ready_vs_busy", {63'd0, in_ready}, {63'd0, ~busy});
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_result: out_valid=1 with nothing pending, y=0x%h", y);
                    end else begin
                        check("y", y, exp_q[0].y);
                        if (!prev_ov)
                            check("latency", 64'(cyc - exp_q[0].acc_edge), 64'(LAT));
                        if (out_ready) begin
                            last_y = y;
                            n_done++;
                            $display("[TB] result %0d: y=0x%h", n_done, y);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                prev_ov = out_valid;
            end
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int          e;
        int          e2;
        int          n;
        int          base;
        logic [63:0] xv;
        logic [63:0] qv;

        fork
            monitor();
            rdy_driver();
        join_none

        // Hand-computed values pin the reference model.
        check("model_x1",   model(64'd1, QM),          64'h0000_0000_0400_0000);
        check("model_2p35", model(64'h8_0000_0000, QM), 64'h1);
        check("model_qm1",  model(QM - 64'd1, QM),      64'h1FFF_FFFF_FBFF_FFFF);

        // Reset state.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y",         y,                 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);

        // 1-3: directed values.
        send(QM, 64'd1, e);
        wait_idle();
        check("t1_y", last_y, 64'h0000_0000_0400_0000);
        send(QM, 64'h0000_0008_0000_0000, e);
        wait_idle();
        check("t2_wrap_y", last_y, 64'h1);
        send(QM, 64'd0, e);
        wait_idle();
        check("t2_zero_y", last_y, 64'd0);
        send(QM, QM - 64'd1, e);
        wait_idle();
        check("t3_qm1_y", last_y, 64'h1FFF_FFFF_FBFF_FFFF);

        // Back-to-back throughput with out_ready high: S+2 (S+3) cycles.
        send(QM, 64'd7, e);
        send(QM, 64'd9, e2);
        check("throughput", 64'(e2 - e), 64'(LAT + 2));
        wait_idle();

        // 3: random operands with random consumer stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            xv = {$urandom(), $urandom()} % QM;
            repeat ($urandom_range(0, 2)) step();
            send(QM, xv, e);
        end
        // A few random odd moduli as well.
        for (int i = 0; i < 40; i++) begin
            qv = {$urandom(), $urandom()} | 64'd1;
            xv = {$urandom(), $urandom()} % qv;
            send(qv, xv, e);
        end
        wait_idle();
        rand_rdy  = 1'b0;
        step();

        // 4: back-pressure in DONE.
        out_ready = 1'b0;
        send(QM, 64'h0123_4567_89AB_CDEF % QM, e);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("bp_reached_done", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            x_in     = {$urandom(), $urandom()} % QM;
            step();
            check("bp_in_ready", {63'd0, in_ready},  64'd0);
            check("bp_held",     {63'd0, out_valid}, 64'd1);
        end
        base      = cyc;
        out_ready = 1'b1;
        send(QM, 64'd3, e2);
        check("bp_next_accept", 64'(e2 - base), 64'd2);
        wait_idle();
        check("bp_next_y", last_y, 64'h0000_0000_0C00_0000);

        // 5: asynchronous reset in the middle of RUN.
        send(QM, 64'h0000_0000_DEAD_BEEF, e);
        repeat (12) step();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_run_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_run_y",         y,                  64'd0);
        check("rst_run_busy",      {63'd0, busy},      64'd0);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        send(QM, 64'd1, e);
        wait_idle();
        check("rst_recover_y", last_y, 64'h0000_0000_0400_0000);

`ifdef MONT_LIFT_IN_RED_EN
        // 6: operand in [q, 2q) reduced by the PRE step.
        send(QM, QM + 64'd5, e);
        wait_idle();
        check("t6_prered_y", last_y, 64'h0000_0000_1400_0000);
`else
        // 6: directed x < q run; latency is checked by the monitor.
        send(QM, 64'd5, e);
        wait_idle();
        check("t6_direct_y", last_y, 64'h0000_0000_1400_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
